// File: rtl/soc_pkg.sv
// Shared SoC definitions for the write-back bus: address map, arbiter states, master ids.
package soc_pkg;

    localparam logic [31:0] RAM_BASE   = 32'd0;
    localparam logic [31:0] DRAM_BASE  = 32'd206800;
    localparam logic [31:0] BTN_ADDR   = 32'd411700;
    localparam logic [31:0] ADDR_LIMIT = 32'd411701;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef logic master_id_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Two-master bus bundle plus the shared decoder side of the write-back bus.
interface bus_arbiter_if;

    logic        m0_req, m0_write, m0_lock, m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_write, m1_lock, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_write;

    modport slave (
        input  m0_req, m0_write, m0_lock, m0_addr, m0_wdata,
        input  m1_req, m1_write, m1_lock, m1_addr, m1_wdata,
        output m0_gnt, m0_rvalid, m0_err, m0_rdata,
        output m1_gnt, m1_rvalid, m1_err, m1_rdata,
        output bus_addr, bus_wdata, bus_write,
        input  bus_rdata
    );

    modport master (
        output m0_req, m0_write, m0_lock, m0_addr, m0_wdata,
        output m1_req, m1_write, m1_lock, m1_addr, m1_wdata,
        input  m0_gnt, m0_rvalid, m0_err, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_err, m1_rdata,
        input  bus_addr, bus_wdata, bus_write,
        output bus_rdata
    );

endinterface

// File: rtl/rd_return_tag.sv
// One-deep tag of the last beat: routes read data and error pulses back to the issuing master.
module rd_return_tag
    import soc_pkg::*;
(
    input  logic        clock,
    input  logic        nreset,
    input  logic        beat_i,
    input  logic        write_i,
    input  logic        in_map_i,
    input  master_id_t  id_i,
    input  logic [31:0] bus_rdata_i,
    output logic [1:0]  rvalid_o,
    output logic [1:0]  err_o,
    output logic [31:0] rdata0_o,
    output logic [31:0] rdata1_o
);

    logic       rd_q, rd_d;
    logic       err_q, err_d;
    logic       in_map_q;
    master_id_t id_q;
    logic [31:0] ret_data;

    assign rd_d  = beat_i & ~write_i;
    assign err_d = beat_i & ~in_map_i;

    // The id is captured with the beat, so a handover on the same edge cannot misroute it.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            rd_q     <= 1'b0;
            err_q    <= 1'b0;
            in_map_q <= 1'b0;
            id_q     <= 1'b0;
        end else begin
            rd_q     <= rd_d;
            err_q    <= err_d;
            in_map_q <= in_map_i;
            id_q     <= id_i;
        end
    end

    assign rvalid_o = {rd_q & id_q, rd_q & ~id_q};
    assign err_o    = {err_q & id_q, err_q & ~id_q};
    assign ret_data = (rd_q && in_map_q) ? bus_rdata_i : 32'd0;
    assign rdata0_o = rvalid_o[0] ? ret_data : 32'd0;
    assign rdata1_o = rvalid_o[1] ? ret_data : 32'd0;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter for the write-back bus: registered grant, bounded hold with lock, map check.
//   state | meaning
//   IDLE  | no owner, bus outputs idle
//   OWN0  | master 0 (CPU) owns the bus
//   OWN1  | master 1 (JPEG/DMA) owns the bus
module bus_arbiter
    import soc_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = soc_pkg::ADDR_LIMIT,
    parameter int          MAX_HOLD   = 16,
    parameter int          HOLD_W     = 5
) (
    input  logic       clock,
    input  logic       nreset,
    bus_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_OWN0 = OWN0;
    localparam logic [1:0] ST_OWN1 = OWN1;

    logic [1:0]        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    master_id_t        last_q, last_d;

    master_id_t  owner;
    logic        owned, req_own, req_oth, lock_own, write_own, beat, in_map;
    logic [31:0] addr_own, wdata_own;
    logic [1:0]  oth_state;

    always_comb begin
        owner     = (state_q == ST_OWN1);
        owned     = (state_q == ST_OWN0) || (state_q == ST_OWN1);
        req_own   = owner ? bus.m1_req   : bus.m0_req;
        req_oth   = owner ? bus.m0_req   : bus.m1_req;
        lock_own  = owner ? bus.m1_lock  : bus.m0_lock;
        write_own = owner ? bus.m1_write : bus.m0_write;
        addr_own  = owner ? bus.m1_addr  : bus.m0_addr;
        wdata_own = owner ? bus.m1_wdata : bus.m0_wdata;
        oth_state = owner ? ST_OWN0 : ST_OWN1;
    end

    assign beat   = owned & req_own;
    assign in_map = addr_own < ADDR_LIMIT;

    assign bus.bus_addr  = beat ? addr_own  : 32'd0;
    assign bus.bus_wdata = beat ? wdata_own : 32'd0;
    assign bus.bus_write = beat & write_own & in_map;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.m0_req && bus.m1_req) state_d = last_q ? ST_OWN0 : ST_OWN1;
                else if (bus.m0_req)          state_d = ST_OWN0;
                else if (bus.m1_req)          state_d = ST_OWN1;
            end
            ST_OWN0, ST_OWN1: begin
                if (beat && hold_q != HOLD_W'(MAX_HOLD)) hold_d = hold_q + HOLD_W'(1);
                if (!req_own)
                    state_d = req_oth ? oth_state : ST_IDLE;
                else if (req_oth && !lock_own && hold_q == HOLD_W'(MAX_HOLD - 1))
                    state_d = oth_state;
                if (state_d != state_q) begin
                    last_d = owner;
                    hold_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // last_q resets to master 1 so that master 0 wins the first tie.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end

    assign bus.m0_gnt = (state_q == ST_OWN0);
    assign bus.m1_gnt = (state_q == ST_OWN1);

    logic [1:0] rvalid, err;

    rd_return_tag u_rd_return_tag (
        .clock       (clock),
        .nreset      (nreset),
        .beat_i      (beat),
        .write_i     (write_own),
        .in_map_i    (in_map),
        .id_i        (owner),
        .bus_rdata_i (bus.bus_rdata),
        .rvalid_o    (rvalid),
        .err_o       (err),
        .rdata0_o    (bus.m0_rdata),
        .rdata1_o    (bus.m1_rdata)
    );

    assign bus.m0_rvalid = rvalid[0];
    assign bus.m1_rvalid = rvalid[1];
    assign bus.m0_err    = err[0];
    assign bus.m1_err    = err[1];

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized scoreboard bench for bus_arbiter against an ownership/hold reference model.
module tb_bus_arbiter;
    import soc_pkg::*;

    localparam int MAXH = 16;

    logic clock = 1'b0;
    logic nreset;
    always #5 clock = ~clock;

    bus_arbiter_if bif();

    bus_arbiter #(.ADDR_LIMIT(32'd411701), .MAX_HOLD(16), .HOLD_W(5)) dut (
        .clock  (clock),
        .nreset (nreset),
        .bus    (bif)
    );

    typedef struct {
        int          due;
        int          id;
        logic        is_rd;
        logic        is_err;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    int          m_owner = -1;
    int          m_hold  = 0;
    int          m_last  = 1;
    logic [31:0] rdata_nxt = 32'd0;
    logic        force_en = 1'b0;
    logic [31:0] force_val = 32'd0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_hold  = 0;
        m_last  = 1;
        exp_q.delete();
    endtask

    // Checks the combinational bus view, queues the expected responses, advances ownership.
    task automatic model_cycle();
        logic        req[2], lock[2], wr[2];
        logic [31:0] ad[2], wd[2];
        logic        beat, inmap;
        int          o, t, nxt;
        chk("m0_gnt", bif.m0_gnt, (m_owner == 0) ? 32'd1 : 32'd0);
        chk("m1_gnt", bif.m1_gnt, (m_owner == 1) ? 32'd1 : 32'd0);
        if (!nreset) return;
        req[0] = bif.m0_req;  lock[0] = bif.m0_lock; wr[0] = bif.m0_write;
        ad[0]  = bif.m0_addr; wd[0]   = bif.m0_wdata;
        req[1] = bif.m1_req;  lock[1] = bif.m1_lock; wr[1] = bif.m1_write;
        ad[1]  = bif.m1_addr; wd[1]   = bif.m1_wdata;
        o     = (m_owner < 0) ? 0 : m_owner;
        beat  = (m_owner >= 0) && req[o];
        inmap = ad[o] < 32'd411701;
        chk("bus_addr",  bif.bus_addr,  beat ? ad[o] : 32'd0);
        chk("bus_wdata", bif.bus_wdata, beat ? wd[o] : 32'd0);
        chk("bus_write", bif.bus_write, (beat && wr[o] && inmap) ? 32'd1 : 32'd0);
        rdata_nxt = force_en ? force_val : $urandom();
        if (beat && (!wr[o] || !inmap))
            exp_q.push_back('{due: cyc + 1, id: o, is_rd: !wr[o], is_err: !inmap,
                              rdata: (!wr[o] && inmap) ? rdata_nxt : 32'd0});
        if (m_owner < 0) begin
            if (req[0] && req[1]) nxt = 1 - m_last;
            else if (req[0])      nxt = 0;
            else if (req[1])      nxt = 1;
            else                  nxt = -1;
        end else begin
            t   = 1 - o;
            nxt = o;
            if (!req[o])                                        nxt = req[t] ? t : -1;
            else if (req[t] && !lock[o] && m_hold == MAXH - 1)  nxt = t;
            if (beat) m_hold = (m_hold + 1 > MAXH) ? MAXH : m_hold + 1;
            if (nxt != o) begin
                m_last = o;
                m_hold = 0;
            end
        end
        m_owner = nxt;
    endtask

    task automatic step();
        @(negedge clock);
        model_cycle();
        @(posedge clock);
        #1;
        bif.bus_rdata = rdata_nxt;
    endtask

    task automatic set_m0(input logic req, input logic wr, input logic [31:0] addr, input logic lock);
        bif.m0_req = req; bif.m0_write = wr; bif.m0_addr = addr; bif.m0_lock = lock;
        bif.m0_wdata = $urandom();
    endtask

    task automatic set_m1(input logic req, input logic wr, input logic [31:0] addr, input logic lock);
        bif.m1_req = req; bif.m1_write = wr; bif.m1_addr = addr; bif.m1_lock = lock;
        bif.m1_wdata = $urandom();
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 4))
            0:       return RAM_BASE + 32'($urandom_range(0, 206799));
            1:       return DRAM_BASE + 32'($urandom_range(0, 204899));
            2:       return BTN_ADDR;
            3:       return 32'd411701;
            default: return $urandom();
        endcase
    endfunction

    // Monitor: pops one expectation per cycle in which the DUT presents a response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing response: id %0d rd %0b err %0b due %0d now %0d",
                         exp_q[0].id, exp_q[0].is_rd, exp_q[0].is_err, exp_q[0].due, cyc);
                void'(exp_q.pop_front());
            end
            if (bif.m0_rvalid || bif.m1_rvalid || bif.m0_err || bif.m1_err) begin
                if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected response: rvalid %b%b err %b%b expected none (cycle %0d)",
                             bif.m1_rvalid, bif.m0_rvalid, bif.m1_err, bif.m0_err, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("m0_rvalid", bif.m0_rvalid, (e.is_rd && e.id == 0) ? 32'd1 : 32'd0);
                    chk("m1_rvalid", bif.m1_rvalid, (e.is_rd && e.id == 1) ? 32'd1 : 32'd0);
                    chk("m0_err",    bif.m0_err,    (e.is_err && e.id == 0) ? 32'd1 : 32'd0);
                    chk("m1_err",    bif.m1_err,    (e.is_err && e.id == 1) ? 32'd1 : 32'd0);
                    chk("m0_rdata",  bif.m0_rdata,  (e.is_rd && e.id == 0) ? e.rdata : 32'd0);
                    chk("m1_rdata",  bif.m1_rdata,  (e.is_rd && e.id == 1) ? e.rdata : 32'd0);
                end
            end else begin
                chk("m0_rdata idle", bif.m0_rdata, 32'd0);
                chk("m1_rdata idle", bif.m1_rdata, 32'd0);
            end
        end
    end

    initial begin
        nreset = 1'b0;
        bif.bus_rdata = 32'd0;
        set_m0(0, 0, 0, 0);
        set_m1(0, 0, 0, 0);
        repeat (2) step();
        chk("reset m0_rvalid", bif.m0_rvalid, 0);
        chk("reset m1_rvalid", bif.m1_rvalid, 0);
        chk("reset m0_err",    bif.m0_err, 0);
        chk("reset m1_err",    bif.m1_err, 0);
        chk("reset bus_write", bif.bus_write, 0);
        nreset = 1'b1;

        // Single master write to address 100.
        set_m0(1, 1, 32'd100, 0);
        step();
        chk("t1 m0_gnt", bif.m0_gnt, 1);
        chk("t1 m1_gnt", bif.m1_gnt, 0);
        chk("t1 bus_write", bif.bus_write, 1);
        chk("t1 bus_addr", bif.bus_addr, 32'd100);
        repeat (3) step();
        set_m0(0, 0, 0, 0);
        repeat (2) step();

        // Both requesting across reset release: m0 first, then forced handover every 16 beats.
        nreset = 1'b0;
        model_reset();
        set_m0(1, 1, 32'd200, 0);
        set_m1(1, 1, 32'd300000, 0);
        step();
        nreset = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            step();
            if (i == 1)  chk("t2 m0 first", bif.m0_gnt, 1);
            if (i == 17) chk("t2 m1 after 16", bif.m1_gnt, 1);
            if (i == 33) chk("t2 m0 back after 16", bif.m0_gnt, 1);
        end
        set_m0(0, 0, 0, 0);
        set_m1(0, 0, 0, 0);
        repeat (2) step();

        // Locked master 0 keeps the bus until it releases.
        set_m0(1, 1, 32'd5000, 1);
        step();
        set_m1(1, 0, 32'd7, 0);
        for (int i = 0; i < 40; i++) begin
            step();
            chk("t3 lock m0_gnt", bif.m0_gnt, 1);
        end
        set_m0(0, 0, 0, 0);
        step();
        chk("t3 handover m1_gnt", bif.m1_gnt, 1);
        chk("t3 handover m0_gnt", bif.m0_gnt, 0);
        set_m1(0, 0, 0, 0);
        repeat (2) step();

        // Master 1 read of the dual-RAM base.
        force_en = 1'b1;
        force_val = 32'hDEADBEEF;
        set_m1(1, 0, DRAM_BASE, 0);
        repeat (2) step();
        chk("t4 m1_rvalid", bif.m1_rvalid, 1);
        chk("t4 m1_rdata", bif.m1_rdata, 32'hDEADBEEF);
        chk("t4 m0_rvalid", bif.m0_rvalid, 0);
        set_m1(0, 0, 0, 0);
        step();
        force_en = 1'b0;
        step();

        // Out-of-map write then read by master 0.
        set_m0(1, 1, 32'd411701, 0);
        repeat (2) step();
        chk("t5 wr m0_err", bif.m0_err, 1);
        set_m0(1, 0, 32'hFFFFFFFF, 0);
        step();
        chk("t5 rd m0_rvalid", bif.m0_rvalid, 1);
        chk("t5 rd m0_rdata", bif.m0_rdata, 0);
        set_m0(0, 0, 0, 0);
        step();
        chk("t5 err single pulse", bif.m0_err, 0);
        step();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0)
                set_m0($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), rand_addr(),
                       $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0)
                set_m1($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), rand_addr(),
                       $urandom_range(0, 4) == 0);
            step();
        end
        set_m0(0, 0, 0, 0);
        set_m1(0, 0, 0, 0);
        repeat (3) step();

        // Asynchronous reset while a read response is on the bus.
        set_m0(1, 0, 32'd5, 0);
        repeat (2) step();
        #1;
        nreset = 1'b0;
        #1;
        chk("t7 m0_gnt in reset", bif.m0_gnt, 0);
        chk("t7 m1_gnt in reset", bif.m1_gnt, 0);
        chk("t7 m0_rvalid in reset", bif.m0_rvalid, 0);
        chk("t7 m0_err in reset", bif.m0_err, 0);
        chk("t7 m1_err in reset", bif.m1_err, 0);
        model_reset();
        set_m0(0, 0, 0, 0);
        step();
        nreset = 1'b1;
        repeat (5) step();
        chk("t7 no rvalid after release", bif.m0_rvalid, 0);

        repeat (3) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
